// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC capture controller.
// Group map: ADC96 groups occupy 0..23, ADC48 groups follow from ADC48_BASE.
package adc_capture_pkg;

    localparam int NUM_GRP_ADC96  = 24;
    localparam int NUM_GRP_ADC48  = 12;
    localparam int ADC48_BASE     = NUM_GRP_ADC96;
    localparam int NUM_GRP_DEF    = ADC48_BASE + NUM_GRP_ADC48;
    localparam int ADDR_W_DEF     = 12;
    localparam int SETTLE_CYC_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_CAPTURE   = 3'd3,
        ST_DONE      = 3'd4
    } cap_state_t;

endpackage

// File: rtl/adc_capture_trig.sv
// Trigger rising-edge detector and post-select settle counter.
module adc_capture_trig
    import adc_capture_pkg::*;
#(
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic trig_in,
    input  logic settle_load,
    output logic trig_rise,
    output logic settle_done
);

    localparam int              CNT_W    = $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             trig_prev;
    logic [CNT_W-1:0] settle_cnt;

    // The previous-cycle trigger is tracked continuously so a level that is
    // already high when the FSM starts waiting is never seen as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_prev  <= 1'b0;
            settle_cnt <= '0;
        end else begin
            trig_prev <= trig_in;
            if (settle_load) begin
                settle_cnt <= CNT_LOAD;
            end else if (settle_cnt != '0) begin
                settle_cnt <= settle_cnt - CNT_ONE;
            end
        end
    end

    assign trig_rise   = trig_in && !trig_prev;
    assign settle_done = (settle_cnt == '0);

endmodule

// File: rtl/adc_capture_ctrl.sv
// Capture-run sequencer: group select, settle, trigger, stream into capture RAM.
// Optional decimation (DECIM port) is built when ADC_CAPTURE_DECIM_EN is defined.
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int NUM_GRP    = NUM_GRP_DEF
) (
    input  logic              CLK500M,
    input  logic              RST,
    input  logic              START,
    input  logic              ABORT,
    input  logic [5:0]        GRP_SEL,
    input  logic [ADDR_W:0]   CAPTURE_LEN,
    input  logic              TRIG_MODE,
    input  logic              TRIG_IN,
    input  logic [35:0]       DATA_IN,
`ifdef ADC_CAPTURE_DECIM_EN
    input  logic [3:0]        DECIM,
`endif
    output logic [5:0]        MUX_SEL,
    output logic              WR_EN,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [35:0]       WR_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              CFG_ERR
);

    localparam logic [5:0]      GRP_LIMIT = 6'(NUM_GRP);
    localparam logic [ADDR_W:0] LEN_MAX   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LEN_ONE   = (ADDR_W + 1)'(1);

    cap_state_t        state_q;
    cap_state_t        state_nxt;
    logic              start_win;
    logic              cfg_bad;
    logic              accept;
    logic              write_now;
    logic              last_write;
    logic              trig_rise;
    logic              settle_done;
    logic [5:0]        mux_sel_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   word_cnt;
    logic              cfg_err_q;
    logic              wr_en_p1;
    logic [ADDR_W-1:0] wr_addr_p1;
    logic [35:0]       wr_data_p1;
`ifdef ADC_CAPTURE_DECIM_EN
    logic [3:0]        decim_q;
    logic [3:0]        phase_q;
`endif

    adc_capture_trig #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_trig (
        .clk         (CLK500M),
        .rst         (RST),
        .trig_in     (TRIG_IN),
        .settle_load (accept),
        .trig_rise   (trig_rise),
        .settle_done (settle_done)
    );

    always_ff @(posedge CLK500M or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        start_win = START && !ABORT && (state_q == ST_IDLE || state_q == ST_DONE);
        cfg_bad   = (GRP_SEL >= GRP_LIMIT) || (CAPTURE_LEN == '0) || (CAPTURE_LEN > LEN_MAX);
        accept    = start_win && !cfg_bad;
`ifdef ADC_CAPTURE_DECIM_EN
        write_now = (state_q == ST_CAPTURE) && (phase_q == 4'd0) && !ABORT;
`else
        write_now = (state_q == ST_CAPTURE) && !ABORT;
`endif
        last_write = write_now && (word_cnt == len_q - LEN_ONE);
        state_nxt  = state_q;
        if (ABORT) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: if (accept) state_nxt = ST_SETTLE;
                ST_SETTLE:        if (settle_done) state_nxt = TRIG_MODE ? ST_WAIT_TRIG : ST_CAPTURE;
                ST_WAIT_TRIG:     if (trig_rise) state_nxt = ST_CAPTURE;
                ST_CAPTURE:       if (last_write) state_nxt = ST_DONE;
                default:          state_nxt = ST_IDLE;
            endcase
        end
    end

    // Write stage: DATA_IN captured into the registered RAM write port
    always_ff @(posedge CLK500M or posedge RST) begin
        if (RST) begin
            mux_sel_q  <= '0;
            len_q      <= '0;
            word_cnt   <= '0;
            cfg_err_q  <= 1'b0;
            wr_en_p1   <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
        end else begin
            cfg_err_q <= start_win && cfg_bad;
            wr_en_p1  <= write_now;
            if (accept) begin
                mux_sel_q <= GRP_SEL;
                len_q     <= CAPTURE_LEN;
                word_cnt  <= '0;
            end
            if (write_now) begin
                wr_data_p1 <= DATA_IN;
                wr_addr_p1 <= word_cnt[ADDR_W-1:0];
                word_cnt   <= word_cnt + LEN_ONE;
            end
        end
    end

`ifdef ADC_CAPTURE_DECIM_EN
    // Phase 0 marks a write cycle; the first CAPTURE cycle always writes.
    always_ff @(posedge CLK500M or posedge RST) begin
        if (RST) begin
            decim_q <= '0;
            phase_q <= '0;
        end else if (accept) begin
            decim_q <= DECIM;
            phase_q <= '0;
        end else if (state_q == ST_CAPTURE) begin
            phase_q <= (phase_q == 4'd0) ? decim_q : phase_q - 4'd1;
        end
    end
`endif

    assign MUX_SEL = mux_sel_q;
    assign WR_EN   = wr_en_p1;
    assign WR_ADDR = wr_addr_p1;
    assign WR_DATA = wr_data_p1;
    assign CFG_ERR = cfg_err_q;
    assign BUSY    = (state_q == ST_SETTLE) || (state_q == ST_WAIT_TRIG) || (state_q == ST_CAPTURE);
    assign DONE    = (state_q == ST_DONE);

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: scenario tasks against a write-schedule reference model.
module tb_adc_capture_ctrl;

    localparam int SETTLE = 8;
`ifdef ADC_CAPTURE_DECIM_EN
    localparam bit HAS_DECIM = 1'b1;
    logic [3:0] DECIM;
`else
    localparam bit HAS_DECIM = 1'b0;
`endif

    logic        CLK500M = 1'b0;
    logic        RST, START, ABORT, TRIG_MODE, TRIG_IN;
    logic [5:0]  GRP_SEL;
    logic [12:0] CAPTURE_LEN;
    logic [35:0] DATA_IN;
    logic [5:0]  MUX_SEL;
    logic        WR_EN, BUSY, DONE, CFG_ERR;
    logic [11:0] WR_ADDR;
    logic [35:0] WR_DATA;

    adc_capture_ctrl dut (
        .CLK500M     (CLK500M),
        .RST         (RST),
        .START       (START),
        .ABORT       (ABORT),
        .GRP_SEL     (GRP_SEL),
        .CAPTURE_LEN (CAPTURE_LEN),
        .TRIG_MODE   (TRIG_MODE),
        .TRIG_IN     (TRIG_IN),
        .DATA_IN     (DATA_IN),
`ifdef ADC_CAPTURE_DECIM_EN
        .DECIM       (DECIM),
`endif
        .MUX_SEL     (MUX_SEL),
        .WR_EN       (WR_EN),
        .WR_ADDR     (WR_ADDR),
        .WR_DATA     (WR_DATA),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .CFG_ERR     (CFG_ERR)
    );

    always #5 CLK500M = ~CLK500M;

    typedef struct packed {
        logic [31:0] e;
        logic [11:0] a;
        logic [35:0] d;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    int          edge_n = 0;
    logic [35:0] data_at [int];
    wr_t         wq [$];
    wr_t         eq [$];

    // Edge counter plus random data source; data_at[e] is what edge e samples.
    always @(posedge CLK500M) begin
        edge_n = edge_n + 1;
        #1;
        DATA_IN = {4'($urandom), $urandom};
        data_at[edge_n + 1] = DATA_IN;
    end

    always @(negedge CLK500M) begin
        if (WR_EN === 1'b1) wq.push_back({32'(edge_n), WR_ADDR, WR_DATA});
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK500M);
            #1;
        end
    endtask

    task automatic wait_edge(input int e);
        while (edge_n < e) tick(1);
    endtask

    task automatic start_run(input int grp, input int len, input int mode, input int d, output int k);
        GRP_SEL     = 6'(grp);
        CAPTURE_LEN = 13'(len);
        TRIG_MODE   = mode[0];
`ifdef ADC_CAPTURE_DECIM_EN
        DECIM       = 4'(d);
`endif
        START = 1'b1;
        k     = edge_n + 1;
        tick(1);
        START = 1'b0;
    endtask

    // Reference model: write j is sampled at edge c + j*(d+1), lands at address j.
    task automatic build_exp(input int c, input int len, input int d);
        eq.delete();
        for (int j = 0; j < len; j++) begin
            int e;
            e = c + j * (d + 1);
            eq.push_back({32'(e), 12'(j), data_at[e]});
        end
    endtask

    task automatic test_reset();
        tick(3);
        checks++;
        if ({MUX_SEL, WR_EN, WR_ADDR, WR_DATA, BUSY, DONE, CFG_ERR} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", {MUX_SEL, WR_EN, WR_ADDR, WR_DATA, BUSY, DONE, CFG_ERR});
        end
        @(negedge CLK500M);
        RST = 1'b0;
        tick(1);
    endtask

    task automatic test_immediate();
        int k;
        wq.delete();
        start_run(5, 4, 0, 0, k);
        checks++;
        if (MUX_SEL !== 6'd5) begin errors++; $display("FAIL imm_mux_sel: got %0d required 5", MUX_SEL); end
        checks++;
        if (BUSY !== 1'b1 || DONE !== 1'b0) begin errors++; $display("FAIL imm_busy_done: got %b%b required 10", BUSY, DONE); end
        wait_edge(k + SETTLE);
        checks++;
        if (WR_EN !== 1'b0) begin errors++; $display("FAIL imm_early_wr: got %b required 0", WR_EN); end
        tick(1);
        checks++;
        if (WR_EN !== 1'b1 || WR_ADDR !== 12'd0) begin errors++; $display("FAIL imm_first_wr: got en %b addr %0d required 1/0", WR_EN, WR_ADDR); end
        wait_edge(k + SETTLE + 1 + 3 + 3);
        build_exp(k + SETTLE + 1, 4, 0);
        checks++;
        if (wq.size() != eq.size()) begin errors++; $display("FAIL imm_count: got %0d required %0d", wq.size(), eq.size()); end
        for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
            checks++;
            if (wq[i] !== eq[i]) begin
                errors++;
                $display("FAIL imm_write%0d: got e%0d a%0d d%h required e%0d a%0d d%h", i, wq[i].e, wq[i].a, wq[i].d, eq[i].e, eq[i].a, eq[i].d);
            end
        end
        checks++;
        if (DONE !== 1'b1 || BUSY !== 1'b0 || WR_EN !== 1'b0) begin errors++; $display("FAIL imm_end: got done %b busy %b en %b required 1 0 0", DONE, BUSY, WR_EN); end
    endtask

    task automatic test_triggered();
        int k, t;
        TRIG_IN = 1'b1;
        tick(2);
        wq.delete();
        start_run(30, 2, 1, 0, k);
        wait_edge(k + 30);
        checks++;
        if (wq.size() != 0 || BUSY !== 1'b1 || MUX_SEL !== 6'd30) begin
            errors++;
            $display("FAIL trig_held_level: got writes %0d busy %b mux %0d required 0 1 30", wq.size(), BUSY, MUX_SEL);
        end
        TRIG_IN = 1'b0;
        tick(1);
        TRIG_IN = 1'b1;
        t = edge_n + 1;
        wait_edge(t + 5);
        build_exp(t + 1, 2, 0);
        checks++;
        if (wq.size() != eq.size()) begin errors++; $display("FAIL trig_count: got %0d required %0d", wq.size(), eq.size()); end
        for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
            checks++;
            if (wq[i] !== eq[i]) begin
                errors++;
                $display("FAIL trig_write%0d: got e%0d a%0d d%h required e%0d a%0d d%h", i, wq[i].e, wq[i].a, wq[i].d, eq[i].e, eq[i].a, eq[i].d);
            end
        end
        checks++;
        if (DONE !== 1'b1) begin errors++; $display("FAIL trig_done: got %b required 1", DONE); end
        TRIG_IN = 1'b0;
        tick(1);
    endtask

    task automatic test_bad_cfg();
        int grp_t [5] = '{36, 5, 63, 0, 0};
        int len_t [5] = '{4, 0, 4, 4097, 8191};
        int k;
        grp_t[4] = 36 + $urandom_range(0, 27);
        for (int i = 0; i < 5; i++) begin
            start_run(grp_t[i], len_t[i], 0, 0, k);
            checks++;
            if (CFG_ERR !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b1 || MUX_SEL !== 6'd30) begin
                errors++;
                $display("FAIL bad_cfg%0d: got err %b busy %b done %b mux %0d required 1 0 1 30", i, CFG_ERR, BUSY, DONE, MUX_SEL);
            end
            tick(1);
            checks++;
            if (CFG_ERR !== 1'b0) begin errors++; $display("FAIL bad_cfg%0d_pulse: got %b required 0", i, CFG_ERR); end
        end
    endtask

    task automatic test_abort();
        int k;
        ABORT = 1'b1;
        tick(1);
        ABORT = 1'b0;
        checks++;
        if (DONE !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL abort_done: got done %b busy %b required 0 0", DONE, BUSY); end
        wq.delete();
        start_run(7, 3, 1, 0, k);
        wait_edge(k + 12);
        checks++;
        if (BUSY !== 1'b1) begin errors++; $display("FAIL abort_wait_busy: got %b required 1", BUSY); end
        ABORT = 1'b1;
        tick(1);
        ABORT = 1'b0;
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || WR_EN !== 1'b0 || MUX_SEL !== 6'd7) begin
            errors++;
            $display("FAIL abort_wait: got busy %b done %b en %b mux %0d required 0 0 0 7", BUSY, DONE, WR_EN, MUX_SEL);
        end
        TRIG_IN = 1'b1;
        tick(1);
        TRIG_IN = 1'b0;
        tick(10);
        checks++;
        if (wq.size() != 0) begin errors++; $display("FAIL abort_no_write: got %0d writes required 0", wq.size()); end
        ABORT = 1'b1;
        start_run(9, 3, 0, 0, k);
        ABORT = 1'b0;
        checks++;
        if (BUSY !== 1'b0 || MUX_SEL !== 6'd7 || CFG_ERR !== 1'b0) begin
            errors++;
            $display("FAIL abort_with_start: got busy %b mux %0d err %b required 0 7 0", BUSY, MUX_SEL, CFG_ERR);
        end
        tick(12);
        checks++;
        if (wq.size() != 0 || DONE !== 1'b0) begin errors++; $display("FAIL abort_with_start_idle: got writes %0d done %b required 0 0", wq.size(), DONE); end
    endtask

    task automatic test_random();
        int k, t, c, grp, len, mode, d, dly;
        TRIG_IN = 1'b0;
        for (int r = 0; r < 8; r++) begin
            grp  = $urandom_range(0, 35);
            len  = $urandom_range(1, 24);
            mode = $urandom_range(0, 1);
            d    = HAS_DECIM ? $urandom_range(0, 5) : 0;
            dly  = $urandom_range(0, 6);
            wq.delete();
            start_run(grp, len, mode, d, k);
            checks++;
            if (MUX_SEL !== 6'(grp) || DONE !== 1'b0 || BUSY !== 1'b1) begin
                errors++;
                $display("FAIL rnd%0d_start: got mux %0d done %b busy %b required %0d 0 1", r, MUX_SEL, DONE, BUSY, grp);
            end
            if (mode == 1) begin
                wait_edge(k + SETTLE + dly);
                TRIG_IN = 1'b1;
                t = edge_n + 1;
                c = t + 1;
            end else begin
                c = k + SETTLE + 1;
            end
            wait_edge(c + (len - 1) * (d + 1) + 3);
            TRIG_IN = 1'b0;
            build_exp(c, len, d);
            checks++;
            if (wq.size() != eq.size()) begin errors++; $display("FAIL rnd%0d_count: got %0d required %0d", r, wq.size(), eq.size()); end
            for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
                checks++;
                if (wq[i] !== eq[i]) begin
                    errors++;
                    $display("FAIL rnd%0d_write%0d: got e%0d a%0d d%h required e%0d a%0d d%h", r, i, wq[i].e, wq[i].a, wq[i].d, eq[i].e, eq[i].a, eq[i].d);
                end
            end
            checks++;
            if (DONE !== 1'b1 || BUSY !== 1'b0) begin errors++; $display("FAIL rnd%0d_end: got done %b busy %b required 1 0", r, DONE, BUSY); end
        end
    endtask

    task automatic test_reset_mid_capture();
        int k;
        start_run(11, 20, 0, 0, k);
        wait_edge(k + SETTLE + 4);
        checks++;
        if (WR_EN !== 1'b1) begin errors++; $display("FAIL rst_mid_active: got en %b required 1", WR_EN); end
        #2 RST = 1'b1;
        #1;
        checks++;
        if ({MUX_SEL, WR_EN, WR_ADDR, WR_DATA, BUSY, DONE, CFG_ERR} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %h required 0", {MUX_SEL, WR_EN, WR_ADDR, WR_DATA, BUSY, DONE, CFG_ERR});
        end
        tick(2);
        @(negedge CLK500M);
        RST = 1'b0;
        tick(3);
        checks++;
        if (BUSY !== 1'b0 || WR_EN !== 1'b0 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_idle: got busy %b en %b done %b required 0 0 0", BUSY, WR_EN, DONE);
        end
    endtask

    task automatic test_full_length();
        int k, c, d;
        d = HAS_DECIM ? 2 : 0;
        wq.delete();
        start_run(35, 4096, 0, d, k);
        c = k + SETTLE + 1;
        wait_edge(c + 4095 * (d + 1) + 4);
        build_exp(c, 4096, d);
        checks++;
        if (wq.size() != eq.size()) begin errors++; $display("FAIL full_count: got %0d required %0d", wq.size(), eq.size()); end
        for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
            checks++;
            if (wq[i] !== eq[i]) begin
                errors++;
                $display("FAIL full_write%0d: got e%0d a%0d d%h required e%0d a%0d d%h", i, wq[i].e, wq[i].a, wq[i].d, eq[i].e, eq[i].a, eq[i].d);
            end
        end
        checks++;
        if (wq.size() == 0 || wq[wq.size() - 1].a !== 12'd4095) begin errors++; $display("FAIL full_last_addr: got %0d writes required last addr 4095", wq.size()); end
        checks++;
        if (DONE !== 1'b1 || WR_EN !== 1'b0) begin errors++; $display("FAIL full_done: got done %b en %b required 1 0", DONE, WR_EN); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        START = 1'b0;
        ABORT = 1'b0;
        TRIG_MODE = 1'b0;
        TRIG_IN = 1'b0;
        GRP_SEL = '0;
        CAPTURE_LEN = '0;
        DATA_IN = '0;
`ifdef ADC_CAPTURE_DECIM_EN
        DECIM = '0;
`endif
        test_reset();
        test_immediate();
        test_triggered();
        test_bad_cfg();
        test_abort();
        test_random();
        test_reset_mid_capture();
        test_full_length();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
